// File: rtl/mul_share_arbiter.sv
// Shares one iterative multiplier between two requesters, round-robin, tagged results.
// Latency: response valid 3 cycles plus the multiplier latency after request acceptance.
// Backpressure: one operation in flight; requests are stalled until the owner's response is consumed or flushed.
module mul_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic             req0_word,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic             req1_word,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush0,
    input  logic             flush1,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [XLEN-1:0]  resp0_result,
    output logic [TAG_W-1:0] resp0_tag,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [XLEN-1:0]  resp1_result,
    output logic [TAG_W-1:0] resp1_tag,
    output logic             mul_start,
    output logic [1:0]       mul_op,
    output logic             mul_word_op,
    output logic [XLEN-1:0]  mul_operand_a,
    output logic [XLEN-1:0]  mul_operand_b,
    input  logic [XLEN-1:0]  mul_result,
    input  logic             mul_busy,
    input  logic             mul_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rr;
    logic              r_owner;
    logic              r_discard;
    logic              r_start;
    logic [1:0]        r_op;
    logic              r_word;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;
    logic [TAG_W-1:0]  r_tag;

    logic              w_win;
    logic              w_idle_ok;
    logic              w_accept;
    logic              w_owner_flush;
    logic              w_owner_resp_rdy;
    logic              w_discard_now;

    // Arbitration: a lone valid requester wins, otherwise the rr pointer decides.
    always_comb begin
        w_win = r_rr;
        if (req0_valid && !req1_valid) begin
            w_win = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_win = 1'b1;
        end
    end

    // Reset gating keeps ready low while reset is held so every output reads 0.
    assign w_idle_ok  = (r_state == S_IDLE) && !mul_busy && !reset;
    assign req0_ready = w_idle_ok && !w_win && !flush0;
    assign req1_ready = w_idle_ok &&  w_win && !flush1;
    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign w_owner_flush    = r_owner ? flush1 : flush0;
    assign w_owner_resp_rdy = r_owner ? resp1_ready : resp0_ready;
    // A flush landing in the same cycle as mul_ready still discards the result.
    assign w_discard_now    = r_discard || w_owner_flush;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mul_ready) w_next = w_discard_now ? S_IDLE : S_RESP;
            S_RESP:  if (w_owner_flush || w_owner_resp_rdy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/owner capture, start pulse, discard tracking and result latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr      <= 1'b0;
            r_owner   <= 1'b0;
            r_discard <= 1'b0;
            r_start   <= 1'b0;
            r_op      <= 2'b00;
            r_word    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_tag     <= '0;
            r_result  <= '0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_owner <= w_win;
                r_rr    <= ~w_win;
                r_op    <= w_win ? req1_op  : req0_op;
                r_word  <= (XLEN == 64) ? (w_win ? req1_word : req0_word) : 1'b0;
                r_a     <= w_win ? req1_a   : req0_a;
                r_b     <= w_win ? req1_b   : req0_b;
                r_tag   <= w_win ? req1_tag : req0_tag;
            end
            // The multiplier cannot be aborted: remember the flush until its result returns.
            if (r_state == S_WAIT && mul_ready) begin
                r_discard <= 1'b0;
                r_result  <= mul_result;
            end else if ((r_state == S_ISSUE || r_state == S_WAIT) && w_owner_flush) begin
                r_discard <= 1'b1;
            end
        end
    end

    assign mul_start     = r_start;
    assign mul_op        = r_op;
    assign mul_word_op   = r_word;
    assign mul_operand_a = r_a;
    assign mul_operand_b = r_b;

    assign resp0_valid  = (r_state == S_RESP) && !r_owner;
    assign resp1_valid  = (r_state == S_RESP) &&  r_owner;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp0_tag    = r_tag;
    assign resp1_tag    = r_tag;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a fixed-latency iterative multiplier model.
// Latency: multiplier answers MUL_LAT edges after sampling mul_start.
// Backpressure: response ready is driven per scenario.
module tb_mul_share_arbiter;

    localparam int MUL_LAT  = 6;
    localparam int RESP_LAT = MUL_LAT + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic        req0_word = 1'b0, req1_word = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic        flush0 = 1'b0, flush1 = 1'b0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] resp0_result, resp1_result;
    logic [3:0]  resp0_tag, resp1_tag;
    logic        mul_start;
    logic [1:0]  mul_op;
    logic        mul_word_op;
    logic [31:0] mul_operand_a, mul_operand_b;
    logic [31:0] mul_result = '0;
    logic        mul_busy = 1'b0;
    logic        mul_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int cnt_v0   = 0;
    int cnt_v1   = 0;
    int m_cnt    = 0;
    logic [31:0] m_pend = '0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_word(req0_word),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_word(req1_word),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .flush0(flush0), .flush1(flush1),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_tag(resp0_tag),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_tag(resp1_tag),
        .mul_start(mul_start), .mul_op(mul_op), .mul_word_op(mul_word_op),
        .mul_operand_a(mul_operand_a), .mul_operand_b(mul_operand_b),
        .mul_result(mul_result), .mul_busy(mul_busy), .mul_ready(mul_ready)
    );

    // Reference RV32 multiply: 64-bit product of suitably extended operands.
    function automatic logic [31:0] mul_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Iterative multiplier model; deliberately ignores the arbiter reset.
    always @(posedge clk) begin
        mul_ready <= 1'b0;
        if (mul_start && !mul_busy) begin
            mul_busy <= 1'b1;
            m_cnt    <= MUL_LAT;
            m_pend   <= mul_model(mul_op, mul_operand_a, mul_operand_b);
        end else if (mul_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_busy   <= 1'b0;
                mul_ready  <= 1'b1;
                mul_result <= m_pend;
            end
        end
    end

    // Event counters used for "never happened" checks.
    always @(posedge clk) begin
        if (mul_start)   n_start <= n_start + 1;
        if (resp0_valid) cnt_v0  <= cnt_v0 + 1;
        if (resp1_valid) cnt_v1  <= cnt_v1 + 1;
    end

    task automatic set_req(input int port, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
        if (port == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; req1_valid = 1'b1;
        end
    endtask

    // Hold the pending request until it is accepted (bounded), then drop valid.
    task automatic accept_pending(input int port, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #2;
        end
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic send(input int port, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output logic ok);
        set_req(port, op, a, b, tag);
        accept_pending(port, ok);
    endtask

    // lat counts edges starting with the acceptance edge as 1.
    task automatic wait_resp(input int port, output int lat, output logic ok);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            #2;
            lat++;
            if ((port == 0) ? resp0_valid : resp1_valid) ok = 1'b1;
        end
    endtask

    task automatic take(input int port);
        if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        @(posedge clk);
        #2;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_checks++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, mul_start} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, mul_start}); end
        n_checks++; if ({mul_op, mul_word_op, mul_operand_a, mul_operand_b} !== 67'b0) begin
            n_fail++; $display("FAIL reset_mul_if: got op=%b a=%h b=%h required zeros", mul_op, mul_operand_a, mul_operand_b); end
        n_checks++; if ({resp0_result, resp0_tag, resp1_result, resp1_tag} !== 72'b0) begin
            n_fail++; $display("FAIL reset_resp: got r0=%h r1=%h required zeros", resp0_result, resp1_result); end
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_rr_port0: got req0_ready=%b required 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rr_port1: got req1_ready=%b required 0", req1_ready); end
    endtask

    task automatic test_single_mul();
        logic ok, rok;
        int lat, s0, v1;
        s0 = n_start; v1 = cnt_v1;
        send(0, 2'b00, 32'd7, 32'd6, 4'd3, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b required 1", ok); end
        wait_resp(0, lat, rok);
        n_checks++; if (rok !== 1'b1 || lat != RESP_LAT) begin
            n_fail++; $display("FAIL single_latency: got valid=%b after %0d edges required %0d", rok, lat, RESP_LAT); end
        n_checks++; if (resp0_result !== 32'd42 || resp0_tag !== 4'd3) begin
            n_fail++; $display("FAIL single_result: got %h tag %h required 0000002a tag 3", resp0_result, resp0_tag); end
        n_checks++; if (n_start - s0 != 1) begin
            n_fail++; $display("FAIL single_start_pulses: got %0d required 1", n_start - s0); end
        take(0);
        n_checks++; if (resp0_valid !== 1'b0 || cnt_v1 != v1) begin
            n_fail++; $display("FAIL single_after_take: got resp0_valid=%b resp1 cycles=%0d required 0/0", resp0_valid, cnt_v1 - v1); end
    endtask

    task automatic test_contention();
        logic ok, rok;
        int lat;
        apply_reset();
        set_req(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
        set_req(1, 2'b00, 32'hFFFF_FFFF, 32'd2, 4'd9);
        @(negedge clk);
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL contend_first_winner: got ready0/1=%b%b required 10", req0_ready, req1_ready); end
        @(posedge clk);
        #2 req0_valid = 1'b0;
        wait_resp(0, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp0_result !== 32'hFFFF_FFFE || resp0_tag !== 4'd5) begin
            n_fail++; $display("FAIL contend_p0_result: got v=%b %h tag %h required fffffffe tag 5", rok, resp0_result, resp0_tag); end
        take(0);
        accept_pending(1, ok);
        wait_resp(1, lat, rok);
        n_checks++; if (ok !== 1'b1 || rok !== 1'b1 || resp1_result !== 32'hFFFF_FFFE || resp1_tag !== 4'd9) begin
            n_fail++; $display("FAIL contend_p1_result: got v=%b %h tag %h required fffffffe tag 9", rok, resp1_result, resp1_tag); end
        take(1);
        // A lone port-0 request moves the pointer to port 1 for the next contention.
        send(0, 2'b00, 32'd3, 32'd4, 4'd2, ok);
        wait_resp(0, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp0_result !== 32'd12) begin
            n_fail++; $display("FAIL contend_solo: got v=%b %h required 0000000c", rok, resp0_result); end
        take(0);
        set_req(0, 2'b00, 32'd1, 32'd1, 4'd3);
        set_req(1, 2'b00, 32'd8, 32'd8, 4'd4);
        @(negedge clk);
        n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL contend_rr_winner: got ready0/1=%b%b required 01", req0_ready, req1_ready); end
        @(posedge clk);
        #2 req1_valid = 1'b0;
        wait_resp(1, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp1_result !== 32'd64 || resp1_tag !== 4'd4) begin
            n_fail++; $display("FAIL contend_rr_p1: got v=%b %h tag %h required 00000040 tag 4", rok, resp1_result, resp1_tag); end
        take(1);
        accept_pending(0, ok);
        wait_resp(0, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp0_result !== 32'd1 || resp0_tag !== 4'd3) begin
            n_fail++; $display("FAIL contend_rr_p0: got v=%b %h tag %h required 00000001 tag 3", rok, resp0_result, resp0_tag); end
        take(0);
    endtask

    task automatic test_backpressure();
        logic ok, rok;
        int lat;
        send(0, 2'b11, 32'h8000_0000, 32'd4, 4'hA, ok);
        set_req(1, 2'b00, 32'd10, 32'd10, 4'd1);
        wait_resp(0, lat, rok);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd2 || resp0_tag !== 4'hA
                            || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %h tag %h rdy=%b%b required 1 00000002 tag a rdy=00",
                                   i, resp0_valid, resp0_result, resp0_tag, req0_ready, req1_ready); end
            @(posedge clk);
            #2;
        end
        resp0_ready = 1'b1;
        #1;
        n_checks++; if (req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_early_accept: got req1_ready=%b required 0", req1_ready); end
        @(posedge clk);
        #2 resp0_ready = 1'b0;
        n_checks++; if (resp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_after_handshake: got resp0_valid=%b req1_ready=%b required 0/1", resp0_valid, req1_ready); end
        accept_pending(1, ok);
        wait_resp(1, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp1_result !== 32'd100 || resp1_tag !== 4'd1) begin
            n_fail++; $display("FAIL bp_next_req: got v=%b %h tag %h required 00000064 tag 1", rok, resp1_result, resp1_tag); end
        take(1);
    endtask

    task automatic test_flush_wait();
        logic ok, rok;
        int lat, v0, s0;
        v0 = cnt_v0; s0 = n_start;
        send(0, 2'b00, 32'd9, 32'd9, 4'd2, ok);
        repeat (3) @(posedge clk);
        #2 flush0 = 1'b1;
        @(posedge clk);
        #2 flush0 = 1'b0;
        set_req(1, 2'b01, 32'hFFFF_FFFD, 32'd5, 4'd7);
        accept_pending(1, ok);
        wait_resp(1, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp1_result !== 32'hFFFF_FFFF || resp1_tag !== 4'd7) begin
            n_fail++; $display("FAIL flushw_next: got v=%b %h tag %h required ffffffff tag 7", rok, resp1_result, resp1_tag); end
        n_checks++; if (cnt_v0 != v0) begin
            n_fail++; $display("FAIL flushw_dropped: got %0d resp0 valid cycles required 0", cnt_v0 - v0); end
        n_checks++; if (n_start - s0 != 2) begin
            n_fail++; $display("FAIL flushw_starts: got %0d required 2", n_start - s0); end
        take(1);
    endtask

    task automatic test_flush_resp();
        logic ok, rok;
        int lat, s0;
        send(1, 2'b00, 32'd2, 32'd3, 4'd4, ok);
        wait_resp(1, lat, rok);
        n_checks++; if (rok !== 1'b1 || resp1_result !== 32'd6) begin
            n_fail++; $display("FAIL flushr_valid: got v=%b %h required 00000006", rok, resp1_result); end
        flush1 = 1'b1;
        @(posedge clk);
        #2 flush1 = 1'b0;
        n_checks++; if (resp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL flushr_dropped: got resp1_valid=%b required 0", resp1_valid); end
        s0 = n_start;
        flush0 = 1'b1;
        set_req(0, 2'b00, 32'd4, 32'd4, 4'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++; $display("FAIL flushr_block[%0d]: got ready0/1=%b%b required 00", i, req0_ready, req1_ready); end
        end
        @(posedge clk);
        #2 req0_valid = 1'b0;
        flush0 = 1'b0;
        n_checks++; if (n_start != s0) begin
            n_fail++; $display("FAIL flushr_no_start: got %0d pulses required 0", n_start - s0); end
    endtask

    task automatic test_reset_wait();
        logic ok, rok;
        int lat, v0, v1;
        send(0, 2'b00, 32'd5, 32'd5, 4'd1, ok);
        repeat (3) @(posedge clk);
        #2;
        v0 = cnt_v0; v1 = cnt_v1;
        reset = 1'b1;
        #1;
        n_checks++; if ({mul_start, resp0_valid, resp1_valid, req0_ready, req1_ready} !== 5'b0) begin
            n_fail++; $display("FAIL rstw_flags: got %b required 00000", {mul_start, resp0_valid, resp1_valid, req0_ready, req1_ready}); end
        n_checks++; if ({mul_operand_a, mul_operand_b, mul_op} !== 66'b0) begin
            n_fail++; $display("FAIL rstw_operands: got a=%h b=%h op=%b required zeros", mul_operand_a, mul_operand_b, mul_op); end
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 40 && mul_busy; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (cnt_v0 != v0 || cnt_v1 != v1) begin
            n_fail++; $display("FAIL rstw_stale_ignored: got resp cycles %0d/%0d required 0/0", cnt_v0 - v0, cnt_v1 - v1); end
        send(1, 2'b00, 32'd11, 32'd3, 4'd6, ok);
        wait_resp(1, lat, rok);
        n_checks++; if (ok !== 1'b1 || rok !== 1'b1 || lat != RESP_LAT || resp1_result !== 32'd33 || resp1_tag !== 4'd6) begin
            n_fail++; $display("FAIL rstw_new_req: got v=%b lat=%0d %h tag %h required lat %0d 00000021 tag 6",
                               rok, lat, resp1_result, resp1_tag, RESP_LAT); end
        take(1);
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_contention();
        test_backpressure();
        test_flush_wait();
        test_flush_resp();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one iterative multiplier (mul_start/mul_ready interface) between two requesters, e.g. the integer pipeline M-stage (port 0) and a secondary issue source (port 1).
- Does round-robin arbitration, registers operands and the start pulse, waits for the multiplier's done pulse, and returns a tagged result over a valid/ready response channel.
- Supports per-requester flush: the multiplication in flight for a flushed owner completes internally, and its result is discarded.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- TAG_W, 4, requester tag width, returned unchanged with the result.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- reqN_valid  in  1  request N valid (N = 0,1)
- reqN_ready  out  1  request N accepted this cycle when valid & ready
- reqN_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- reqN_word  in  1  RV64 W-op; ignored when XLEN = 32
- reqN_a, reqN_b  in  XLEN  operands
- reqN_tag  in  TAG_W  tag
- flushN  in  1  discard any request from N that is in flight or pending response
- respN_valid  out  1  result available for N
- respN_ready  in  1  N consumes the result
- respN_result  out  XLEN  product
- respN_tag  out  TAG_W  tag of the originating request
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_op  out  2  registered op
- mul_word_op  out  1  registered word flag
- mul_operand_a, mul_operand_b  out  XLEN  registered operands
- mul_result  in  XLEN  multiplier result
- mul_busy  in  1  multiplier busy
- mul_ready  in  1  one-cycle result pulse

Behaviour:
- Reset values: all outputs 0. State = IDLE, rr pointer = 0 (port 0 has priority), discard flag = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, with mul_busy = 0, for the arbitration winner, and only if flushN = 0.
  - Winner: the sole valid requester. If both are valid, the port selected by the rr pointer wins.
  - On handshake: capture op, word, a, b, tag and owner. Set the rr pointer to the other port. Go to ISSUE.
- ISSUE: mul_start = 1 for exactly one cycle, operands stable. Go to WAIT.
- WAIT:
  - Operands are held stable until mul_ready.
  - On mul_ready: latch mul_result. If the discard flag is set, clear it and go to IDLE with no response. Otherwise go to RESP.
- RESP:
  - resp<owner>_valid = 1, with result and tag held stable until resp<owner>_ready. respN_valid is never asserted for the non-owner.
  - On the ready handshake go to IDLE. A new request is accepted no earlier than the cycle after the response handshake.
- Flush:
  - flush<owner> in ISSUE or WAIT sets the discard flag. The multiplier cannot be aborted, so the FSM still waits for mul_ready.
  - flush<owner> in RESP drops respN_valid on the next edge and returns to IDLE.
  - flushN for the non-owner has no effect on the current operation.
  - Flush and handshake in the same cycle: flush wins and the request is not accepted.
- If mul_ready arrives in a state other than WAIT, it is ignored.
- Reset asserted mid-operation returns to reset values immediately. The multiplier result pending at that point is never reported.
- Latency: response valid appears 3 cycles plus the multiplier latency after acceptance. With the 32-bit iterative multiplier this is a fixed number of cycles, checked by the bench.

Test Plan:
- Single MUL: req0 op=00, a=7, b=6, tag=3 -> exactly one mul_start pulse; resp0_valid with result=42, tag=3; resp1_valid stays 0.
- Contention after reset: req0 (MULHU, a=b=0xFFFFFFFF) and req1 (MUL, a=0xFFFFFFFF, b=2) both valid -> port 0 served first with result 0xFFFFFFFE; then port 1 with result 0xFFFFFFFE, tag preserved. Next simultaneous request -> port 1 served first, if the pointer points to 1.
- Backpressure: resp0_ready held low for 5 cycles -> result and tag stable, reqN_ready stays 0; after the handshake the next request is accepted.
- Flush in WAIT: flush0 pulsed 4 cycles after acceptance -> no resp0_valid; after mul_ready the FSM returns to IDLE; a following req1 (MULH, a=-3, b=5) returns 0xFFFFFFFF.
- Flush in RESP and the same-cycle flush-vs-handshake rule -> response dropped; the flushed request is never accepted.
- Reset asserted during WAIT -> all outputs 0 immediately; the stale mul_ready pulse that follows is ignored; a new request works normally.
